indicadores_planta: RTL and testbench
=====================================

INDICADORES_PLANTA -- requirements
Module: indicadores_planta

Interface
REQ-001 Parameter DECAY_CYCLES, default 50000000, clk cycles between decay ticks.
REQ-002 Parameter COOLDOWN, default 25000000, clk cycles after an accepted action during which further actions are ignored.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous active-low reset; sampled on posedge clk.
REQ-005 btn_regar, btn_alimentar, btn_limpiar, btn_podar, btn_dormir  input  1 each  synchronous action requests; act on rising edge only.
REQ-006 humedad, nutricion, energia, mantenimiento, podado  output  3 each  registered plant indicators, 0..7.
REQ-007 reposando  output  1  registered; 1 while in DORMIDA.
REQ-008 accion_ack  output  1  one-cycle pulse per accepted action, including sleep toggles.

Function
REQ-009 Each button SHALL have a previous-sample register; an edge SHALL be input high with previous sample low.
REQ-010 Decay counter SHALL count 0..DECAY_CYCLES-1, wrap to 0 and assert an internal tick for one cycle at wrap.
REQ-011 FSM SHALL have two states: ACTIVA (reposando=0) and DORMIDA (reposando=1).
REQ-012 On tick, humedad, nutricion, mantenimiento and podado SHALL each decrement by 1, saturating at 0.
REQ-013 On tick in ACTIVA, energia SHALL decrement by 1, saturating at 0; in DORMIDA, energia SHALL increment by 1, saturating at 7.
REQ-014 In ACTIVA with cooldown counter zero, an edge on regar/alimentar/limpiar/podar SHALL add 2 to humedad/nutricion/mantenimiento/podado respectively, saturating at 7.
REQ-015 Simultaneous action edges: only one accepted, priority regar > alimentar > limpiar > podar > dormir; the rest are discarded.
REQ-016 Action and tick in the same cycle on one indicator: net change +1, saturating at 0..7; no change is lost.
REQ-017 Updated indicators and accion_ack SHALL be visible on the clk edge following the cycle the edge is detected (latency 1).
REQ-018 An accepted action SHALL load the cooldown counter with COOLDOWN-1; it decrements each cycle to 0, and actions are accepted only at 0.
REQ-019 ACTIVA to DORMIDA on an accepted btn_dormir edge.
REQ-020 DORMIDA to ACTIVA on a btn_dormir edge with cooldown 0 (acked), or automatically on the cycle after energia reaches 7 (no ack).
REQ-021 In DORMIDA, edges on regar/alimentar/limpiar/podar SHALL be ignored without ack.
REQ-022 Rising edges during cooldown SHALL be discarded, not queued.

Reset
REQ-023 With rst low at posedge clk, all five indicators SHALL be 7, reposando 0, accion_ack 0, FSM ACTIVA, decay and cooldown counters 0.
REQ-024 Reset SHALL set all previous-sample registers to 1, so a button held through reset produces no action.
REQ-025 Reset mid-cooldown or mid-sleep SHALL override all other activity in that cycle.

Configuration
REQ-026 With INDICADORES_FAST_EN defined, effective DECAY_CYCLES SHALL be 16 and COOLDOWN 4, regardless of parameter values.
REQ-027 Without INDICADORES_FAST_EN, the parameter values SHALL apply unchanged.

Verification (INDICADORES_FAST_EN defined)
REQ-028 Release rst, idle 48 cycles -> 3 ticks; all indicators 4; reposando 0; no ack.
REQ-029 From humedad=4, one regar pulse -> humedad 6 one cycle later, with one accion_ack pulse; a second regar edge 2 cycles later -> ignored.
REQ-030 alimentar and podar rise in the same cycle -> only nutricion +2, one ack; podado unchanged.
REQ-031 regar edge in the same cycle as a tick, humedad=7 -> humedad 7 (the +1 net change saturates at 7); with humedad=3 -> 4.
REQ-032 energia=4, dormir pulse -> reposando 1; energia 5,6,7 on the next three ticks; reposando 0 the cycle after 7; regar during sleep has no effect.
REQ-033 btn_regar held high through reset and after -> no action and no ack; rst asserted in DORMIDA with energia 5 -> all indicators 7, reposando 0.

Source files
------------

// File: rtl/indicadores_planta.sv
// rtl/indicadores_planta.sv - virtual plant indicators with decay ticks, action cooldown and sleep FSM
// Optional macro INDICADORES_FAST_EN: forces decay period 16 and cooldown 4 for fast simulation.
module indicadores_planta #(
  parameter int DECAY_CYCLES = 50000000,
  parameter int COOLDOWN     = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_regar,
  input  logic       btn_alimentar,
  input  logic       btn_limpiar,
  input  logic       btn_podar,
  input  logic       btn_dormir,
  output logic [2:0] humedad,
  output logic [2:0] nutricion,
  output logic [2:0] energia,
  output logic [2:0] mantenimiento,
  output logic [2:0] podado,
  output logic       reposando,
  output logic       accion_ack
);

`ifdef INDICADORES_FAST_EN
  localparam int DEC_EFF  = 16;
  localparam int COOL_EFF = 4;
`else
  localparam int DEC_EFF  = DECAY_CYCLES;
  localparam int COOL_EFF = COOLDOWN;
`endif

  localparam int DW = (DEC_EFF > 1) ? $clog2(DEC_EFF) : 1;
  localparam int CW = (COOL_EFF > 1) ? $clog2(COOL_EFF) : 1;

  typedef enum logic {
    ACTIVA  = 1'b0,
    DORMIDA = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] decay_cnt;
  logic [CW-1:0] cooldown_cnt;
  logic          tick;

  // Button vector order: {dormir, podar, limpiar, alimentar, regar}
  logic [4:0] btns;
  logic [4:0] btn_prev;
  logic [4:0] edges;

  logic act_regar, act_alimentar, act_limpiar, act_podar, act_dormir;
  logic accept;

  logic signed [2:0] d_hum, d_nut, d_ene, d_man, d_pod;

  assign btns  = {btn_dormir, btn_podar, btn_limpiar, btn_alimentar, btn_regar};
  assign edges = btns & ~btn_prev;
  assign tick  = (decay_cnt == DW'(DEC_EFF - 1));
  assign reposando = (state == DORMIDA);

  // Clamp value+delta into the 0..7 indicator range so combined action/tick changes are never lost.
  function automatic logic [2:0] sat_add(input logic [2:0] v, input logic signed [2:0] d);
    logic signed [4:0] s;
    s = $signed({2'b00, v}) + $signed({{2{d[2]}}, d});
    if (s < 5'sd0)
      sat_add = 3'd0;
    else if (s > 5'sd7)
      sat_add = 3'd7;
    else
      sat_add = s[2:0];
  endfunction

  // Free-running decay counter; tick is high in the last count before wrapping.
  always_ff @(posedge clk) begin
    if (!rst)
      decay_cnt <= '0;
    else if (tick)
      decay_cnt <= '0;
    else
      decay_cnt <= decay_cnt + DW'(1);
  end

  // Cooldown reloads on each accepted action and counts down to zero.
  always_ff @(posedge clk) begin
    if (!rst)
      cooldown_cnt <= '0;
    else if (accept)
      cooldown_cnt <= CW'(COOL_EFF - 1);
    else if (cooldown_cnt != '0)
      cooldown_cnt <= cooldown_cnt - CW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= ACTIVA;
    else
      state <= state_next;
  end

  // Action arbitration (fixed priority, only when cooldown is idle) and next-state logic.
  always_comb begin
    act_regar     = 1'b0;
    act_alimentar = 1'b0;
    act_limpiar   = 1'b0;
    act_podar     = 1'b0;
    act_dormir    = 1'b0;
    state_next    = state;
    if (cooldown_cnt == '0) begin
      if (state == ACTIVA) begin
        if (edges[0])      act_regar     = 1'b1;
        else if (edges[1]) act_alimentar = 1'b1;
        else if (edges[2]) act_limpiar   = 1'b1;
        else if (edges[3]) act_podar     = 1'b1;
        else if (edges[4]) act_dormir    = 1'b1;
      end else begin
        // While sleeping only the sleep button is honoured.
        if (edges[4]) act_dormir = 1'b1;
      end
    end
    accept = act_regar | act_alimentar | act_limpiar | act_podar | act_dormir;
    if (act_dormir)
      state_next = (state == ACTIVA) ? DORMIDA : ACTIVA;
    else if (state == DORMIDA && energia == 3'd7)
      state_next = ACTIVA;
  end

  // Per-indicator delta: +2 for its action, -1 on decay (energia recovers while asleep).
  always_comb begin
    d_hum = 3'sd0;
    d_nut = 3'sd0;
    d_man = 3'sd0;
    d_pod = 3'sd0;
    d_ene = 3'sd0;
    if (act_regar)     d_hum = d_hum + 3'sd2;
    if (act_alimentar) d_nut = d_nut + 3'sd2;
    if (act_limpiar)   d_man = d_man + 3'sd2;
    if (act_podar)     d_pod = d_pod + 3'sd2;
    if (tick) begin
      d_hum = d_hum - 3'sd1;
      d_nut = d_nut - 3'sd1;
      d_man = d_man - 3'sd1;
      d_pod = d_pod - 3'sd1;
      d_ene = (state == DORMIDA) ? 3'sd1 : -3'sd1;
    end
  end

  // Indicator, ack and edge-history registers; history resets high so held buttons do not fire.
  always_ff @(posedge clk) begin
    if (!rst) begin
      humedad       <= 3'd7;
      nutricion     <= 3'd7;
      energia       <= 3'd7;
      mantenimiento <= 3'd7;
      podado        <= 3'd7;
      accion_ack    <= 1'b0;
      btn_prev      <= 5'b11111;
    end else begin
      humedad       <= sat_add(humedad, d_hum);
      nutricion     <= sat_add(nutricion, d_nut);
      energia       <= sat_add(energia, d_ene);
      mantenimiento <= sat_add(mantenimiento, d_man);
      podado        <= sat_add(podado, d_pod);
      accion_ack    <= accept;
      btn_prev      <= btns;
    end
  end

endmodule

// File: tb/tb_indicadores_planta.sv
// tb/tb_indicadores_planta.sv - self-checking bench for indicadores_planta
module tb_indicadores_planta;

  logic       clk;
  logic       rst;
  logic       btn_regar, btn_alimentar, btn_limpiar, btn_podar, btn_dormir;
  logic [2:0] humedad, nutricion, energia, mantenimiento, podado;
  logic       reposando, accion_ack;

  indicadores_planta #(
    .DECAY_CYCLES(16),
    .COOLDOWN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_regar(btn_regar),
    .btn_alimentar(btn_alimentar),
    .btn_limpiar(btn_limpiar),
    .btn_podar(btn_podar),
    .btn_dormir(btn_dormir),
    .humedad(humedad),
    .nutricion(nutricion),
    .energia(energia),
    .mantenimiento(mantenimiento),
    .podado(podado),
    .reposando(reposando),
    .accion_ack(accion_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         due;
    logic [2:0] hum, nut, ene, man, pod;
    logic       rep, ack;
  } exp_t;

  typedef struct {
    string      name;
    logic [4:0] btns;  // {dormir, podar, limpiar, alimentar, regar}
    int         hum, nut, man, pod, rep, ack;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[7];
  int   total, bad, cyc;

  task automatic expect_at(input string name, input int due, input int hum, input int nut,
                           input int ene, input int man, input int pod, input int rep, input int ack);
    exp_t e;
    e.name = name; e.due = due;
    e.hum = 3'(hum); e.nut = 3'(nut); e.ene = 3'(ene); e.man = 3'(man); e.pod = 3'(pod);
    e.rep = 1'(rep); e.ack = 1'(ack);
    sbq.push_back(e);
  endtask

  task automatic check_due();
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      total++;
      if ({humedad, nutricion, energia, mantenimiento, podado, reposando, accion_ack} !==
          {e.hum, e.nut, e.ene, e.man, e.pod, e.rep, e.ack}) begin
        bad++;
        $display("FAIL %s cyc=%0d got h%0d n%0d e%0d m%0d p%0d r%0d a%0d want h%0d n%0d e%0d m%0d p%0d r%0d a%0d",
                 e.name, cyc, humedad, nutricion, energia, mantenimiento, podado, reposando, accion_ack,
                 e.hum, e.nut, e.ene, e.man, e.pod, e.rep, e.ack);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_due();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic set_btns(input logic [4:0] m);
    btn_regar     = m[0];
    btn_alimentar = m[1];
    btn_limpiar   = m[2];
    btn_podar     = m[3];
    btn_dormir    = m[4];
  endtask

  initial begin
    vecs[0] = '{"pri_regar",       5'b00001, 6, 4, 4, 4, 0, 1};
    vecs[1] = '{"pri_alim_podar",  5'b01010, 4, 6, 4, 4, 0, 1};
    vecs[2] = '{"pri_limp_podar",  5'b01100, 4, 4, 6, 4, 0, 1};
    vecs[3] = '{"pri_podar_dorm",  5'b11000, 4, 4, 4, 6, 0, 1};
    vecs[4] = '{"pri_dormir",      5'b10000, 4, 4, 4, 4, 1, 1};
    vecs[5] = '{"pri_regar_dorm",  5'b10001, 6, 4, 4, 4, 0, 1};
    vecs[6] = '{"pri_none",        5'b00000, 4, 4, 4, 4, 0, 0};

    total = 0; bad = 0; cyc = 0;
    rst = 1'b0;
    set_btns(5'b00000);

    // Reset state and idle decay
    do_reset();
    expect_at("reset_state", 0, 7, 7, 7, 7, 7, 0, 0);
    check_due();
    expect_at("idle_tick1", 16, 6, 6, 6, 6, 6, 0, 0);
    expect_at("idle_48", 48, 4, 4, 4, 4, 4, 0, 0);
    run_to(48);

    // Single action, then an edge inside cooldown, then one after it
    btn_regar = 1'b1;
    expect_at("regar_ack", 49, 6, 4, 4, 4, 4, 0, 1);
    step();
    btn_regar = 1'b0;
    expect_at("regar_ack_once", 50, 6, 4, 4, 4, 4, 0, 0);
    run_to(51);
    btn_regar = 1'b1;
    expect_at("regar_in_cooldown", 52, 6, 4, 4, 4, 4, 0, 0);
    step();
    btn_regar = 1'b0;
    run_to(54);
    btn_regar = 1'b1;
    expect_at("regar_after_cooldown", 55, 7, 4, 4, 4, 4, 0, 1);
    step();
    btn_regar = 1'b0;

    // Priority table
    for (int i = 0; i < 7; i++) begin
      set_btns(5'b00000);
      do_reset();
      run_to(48);
      set_btns(vecs[i].btns);
      expect_at(vecs[i].name, 49, vecs[i].hum, vecs[i].nut, 4, vecs[i].man, vecs[i].pod,
                vecs[i].rep, vecs[i].ack);
      step();
      set_btns(5'b00000);
      expect_at({vecs[i].name, "_next"}, 50, vecs[i].hum, vecs[i].nut, 4, vecs[i].man, vecs[i].pod,
                vecs[i].rep, 0);
      step();
    end

    // Action coinciding with a decay tick
    do_reset();
    run_to(15);
    btn_regar = 1'b1;
    expect_at("tick_regar_sat", 16, 7, 6, 6, 6, 6, 0, 1);
    step();
    btn_regar = 1'b0;
    expect_at("tick80", 80, 3, 2, 2, 2, 2, 0, 0);
    run_to(95);
    btn_regar = 1'b1;
    expect_at("tick_regar_from3", 96, 4, 1, 1, 1, 1, 0, 1);
    step();
    btn_regar = 1'b0;

    // Sleep: energy recovery, ignored actions, automatic wake
    do_reset();
    run_to(48);
    btn_dormir = 1'b1;
    expect_at("sleep_enter", 49, 4, 4, 4, 4, 4, 1, 1);
    step();
    btn_dormir = 1'b0;
    run_to(55);
    btn_regar = 1'b1;
    expect_at("sleep_regar_ignored", 56, 4, 4, 4, 4, 4, 1, 0);
    step();
    btn_regar = 1'b0;
    expect_at("sleep_tick_e5", 64, 3, 3, 5, 3, 3, 1, 0);
    expect_at("sleep_tick_e6", 80, 2, 2, 6, 2, 2, 1, 0);
    expect_at("sleep_tick_e7", 96, 1, 1, 7, 1, 1, 1, 0);
    expect_at("auto_wake", 97, 1, 1, 7, 1, 1, 0, 0);
    expect_at("awake_decay", 112, 0, 0, 6, 0, 0, 0, 0);
    run_to(112);

    // Button held through reset
    btn_regar = 1'b1;
    do_reset();
    expect_at("held_reset", 0, 7, 7, 7, 7, 7, 0, 0);
    check_due();
    expect_at("held_no_ack", 1, 7, 7, 7, 7, 7, 0, 0);
    expect_at("held_tick", 17, 6, 6, 6, 6, 6, 0, 0);
    run_to(17);
    btn_regar = 1'b0;
    run_to(19);
    btn_regar = 1'b1;
    expect_at("held_then_press", 20, 7, 6, 6, 6, 6, 0, 1);
    step();
    btn_regar = 1'b0;

    // Reset while asleep, with a competing sleep edge
    do_reset();
    run_to(32);
    btn_dormir = 1'b1;
    expect_at("sleep_e5", 33, 5, 5, 5, 5, 5, 1, 1);
    step();
    btn_dormir = 1'b0;
    run_to(36);
    btn_dormir = 1'b1;
    do_reset();
    expect_at("reset_in_sleep", 0, 7, 7, 7, 7, 7, 0, 0);
    check_due();
    btn_dormir = 1'b0;
    expect_at("after_sleep_reset", 1, 7, 7, 7, 7, 7, 0, 0);
    step();

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
